// File: rtl/pipe_seq_ctrl.sv
// Sequencing controller for the 5-input load-enabled pipeline: handshakes vectors in,
// tracks valid tokens through DEPTH stages, and buffers results behind a ready/valid output.
module pipe_seq_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             drain_req,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    output logic             in_ready,
    output logic             pipe_clr,
    output logic             pipe_load,
    output logic [4:0]       pipe_in,
    input  logic             pipe_f,
    output logic             out_valid,
    output logic             out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             drain_done,
    output logic [CNT_W-1:0] result_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e             state_q;
    logic [DEPTH-1:0]   vld_q;
    logic [DEPTH-1:0]   vld_d;
    logic               out_valid_q;
    logic               out_data_q;
    logic               drain_done_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               adv;
    logic               accept;

    assign adv       = !out_valid_q || out_ready;
    assign pipe_clr  = clr || abort;
    assign pipe_load = adv && (state_q != S_IDLE) && !abort;
    assign in_ready  = adv && (state_q == S_RUN) && !abort;
    assign accept    = in_valid && in_ready;
    assign pipe_in   = accept ? in_data : '0;
    assign busy      = (state_q != S_IDLE);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign drain_done = drain_done_q;
    assign result_cnt = cnt_q;

    // Token shift written as a loop so DEPTH=1 needs no special-cased slice.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 1'b0;
            drain_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            drain_done_q <= 1'b0;
            if (out_valid_q && out_ready && !abort) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (abort) begin
                state_q     <= S_IDLE;
                vld_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (pipe_load) begin
                    vld_q       <= vld_d;
                    out_valid_q <= vld_q[DEPTH-1];
                    if (vld_q[DEPTH-1]) begin
                        out_data_q <= pipe_f;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (drain_req) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if ((vld_q == '0) && adv) begin
                            state_q      <= S_IDLE;
                            drain_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: XOR-reducing DEPTH=2 pipeline stub, scoreboard of accepted
// vectors, directed sequences for stream/backpressure/drain/abort/collisions, plus a random run.
module tb_pipe_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, drain_req, abort, in_valid, out_ready;
    logic [4:0] in_data;
    logic       in_ready, pipe_clr, pipe_load, pipe_f, out_valid, out_data, busy, drain_done;
    logic [4:0] pipe_in;
    logic [7:0] result_cnt;

    logic       in_ready_2, pipe_clr_2, pipe_load_2, out_valid_2, out_data_2, busy_2, drain_done_2;
    logic [4:0] pipe_in_2;
    logic [1:0] cnt2;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cnt_exp = 0;
    bit          armed = 1'b0;
    bit          sb[$];

    always #5 clk = ~clk;

    pipe_seq_ctrl #(.DEPTH(2), .CNT_W(8)) u_dut (
        .clk(clk), .clr(clr), .start(start), .drain_req(drain_req), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pipe_clr(pipe_clr), .pipe_load(pipe_load), .pipe_in(pipe_in), .pipe_f(pipe_f),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .drain_done(drain_done), .result_cnt(result_cnt)
    );

    pipe_seq_ctrl #(.DEPTH(2), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .clr(clr), .start(start), .drain_req(drain_req), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_2),
        .pipe_clr(pipe_clr_2), .pipe_load(pipe_load_2), .pipe_in(pipe_in_2), .pipe_f(pipe_f),
        .out_valid(out_valid_2), .out_data(out_data_2), .out_ready(out_ready),
        .busy(busy_2), .drain_done(drain_done_2), .result_cnt(cnt2)
    );

    logic [4:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (pipe_clr) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (pipe_load) begin
            s1_q <= pipe_in;
            s2_q <= s1_q;
        end
    end
    assign pipe_f = ^s2_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("cnt", 32'(result_cnt), cnt_exp & 32'hFF);
            check("cnt_w2", 32'(cnt2), cnt_exp & 32'h3);
            if (clr) begin
                sb.delete();
                cnt_exp = 0;
            end else if (abort) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        check("sb_data", 32'(out_data), 32'(sb.pop_front()));
                    end
                    cnt_exp++;
                end
                if (in_valid && in_ready) begin
                    sb.push_back(^in_data);
                end
            end
        end
    end

    task automatic feed(input logic [4:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        check("feed_rdy", 32'(in_ready), 1);
        check("feed_pin", 32'(pipe_in), 32'(v));
        check("feed_load", 32'(pipe_load), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int unsigned target, input int unsigned bound);
        bit reached = 1'b0;
        for (int unsigned n = 0; n < bound; n++) begin
            @(negedge clk);
            if (result_cnt == 8'(target)) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        check("wait_cnt", 32'(reached), 1);
        check("wait_ovld", 32'(out_valid), 0);
        check("wait_sb", 32'(sb.size()), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] v_stream[3] = '{5'b11010, 5'b11011, 5'b01110};
        logic [4:0] v_bp[3]     = '{5'b10000, 5'b11000, 5'b11100};
        logic [2:0] r_stream    = 3'b101;
        int unsigned dd_cnt;
        bit idle_seen;

        clr = 1'b1; start = 1'b0; drain_req = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        armed = 1'b1;
        @(negedge clk);
        check("rst_ovld", 32'(out_valid), 0);
        check("rst_odata", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dd", 32'(drain_done), 0);
        check("rst_pclr", 32'(pipe_clr), 1);
        check("rst_load", 32'(pipe_load), 0);
        check("rst_inrdy", 32'(in_ready), 0);
        tick();
        clr = 1'b0;

        // Stream: three back-to-back vectors, results at k+2..k+4
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) feed(v_stream[i]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("strm_ovld", 32'(out_valid), 1);
            check("strm_data", 32'(out_data), 32'(r_stream[2-i]));
            tick();
        end
        @(negedge clk);
        check("strm_done", 32'(out_valid), 0);
        check("strm_cnt", 32'(result_cnt), 3);
        tick();

        // Backpressure with a pending vector held at the input
        for (int i = 0; i < 3; i++) feed(v_bp[i]);
        in_valid  = 1'b1;
        in_data   = 5'b00001;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ovld", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 1);
            check("bp_inrdy", 32'(in_ready), 0);
            check("bp_load", 32'(pipe_load), 0);
            check("bp_pin", 32'(pipe_in), 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        wait_cnt(7, 20);

        // Drain after two accepted vectors
        feed(5'b10101);
        feed(5'b00110);
        drain_req = 1'b1;
        @(negedge clk);
        check("dr_busy", 32'(busy), 1);
        tick();
        drain_req = 1'b0;
        in_valid  = 1'b1;
        in_data   = 5'b11111;
        @(negedge clk);
        check("dr_inrdy", 32'(in_ready), 0);
        check("dr_busy2", 32'(busy), 1);
        tick();
        dd_cnt = 0;
        idle_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            dd_cnt += 32'(drain_done);
            tick();
        end
        check("dr_idle", 32'(idle_seen), 1);
        check("dr_early_dd", dd_cnt, 0);
        check("dr_dd", 32'(drain_done), 1);
        check("dr_cnt", 32'(result_cnt), 9);
        check("dr_ovld", 32'(out_valid), 0);
        check("dr_sb", 32'(sb.size()), 0);
        tick();
        @(negedge clk);
        check("dr_dd_pulse", 32'(drain_done), 0);
        check("dr_busy3", 32'(busy), 0);
        tick();
        in_valid = 1'b0;

        // Abort with out_valid=1 and two tokens in flight
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(5'b00111);
        feed(5'b01111);
        feed(5'b10011);
        in_valid = 1'b1;
        in_data  = 5'b11100;
        abort    = 1'b1;
        @(negedge clk);
        check("ab_ovld", 32'(out_valid), 1);
        check("ab_pclr", 32'(pipe_clr), 1);
        check("ab_inrdy", 32'(in_ready), 0);
        check("ab_load", 32'(pipe_load), 0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ab_ovld0", 32'(out_valid), 0);
            check("ab_busy", 32'(busy), 0);
            check("ab_dd", 32'(drain_done), 0);
            check("ab_cnt", 32'(result_cnt), 9);
            tick();
        end

        // start+drain_req together in IDLE goes to RUN
        start     = 1'b1;
        drain_req = 1'b1;
        tick();
        start     = 1'b0;
        drain_req = 1'b0;
        @(negedge clk);
        check("col_busy", 32'(busy), 1);
        check("col_run", 32'(in_ready), 1);
        tick();

        // clr during RUN with a result showing
        feed(5'b10000);
        feed(5'b00011);
        feed(5'b00111);
        clr = 1'b1;
        @(negedge clk);
        check("clr_ovld_pre", 32'(out_valid), 1);
        check("clr_pclr", 32'(pipe_clr), 1);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_ovld", 32'(out_valid), 0);
        check("clr_odata", 32'(out_data), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_dd", 32'(drain_done), 0);
        check("clr_cnt", 32'(result_cnt), 0);
        check("clr_cnt2", 32'(cnt2), 0);
        tick();

        // Counter wrap on the 2-bit instance
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) feed(5'($urandom_range(0, 31)));
        wait_cnt(5, 20);
        @(negedge clk);
        check("wrap_cnt2", 32'(cnt2), 1);
        tick();

        // Random traffic with random backpressure, then drain
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        idle_seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            tick();
        end
        check("rnd_idle", 32'(idle_seen), 1);
        check("rnd_dd", 32'(drain_done), 1);
        check("rnd_sb", 32'(sb.size()), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Sequencing controller for the team's 5-input, 1-output load-enabled pipeline (inputs a..e, output f, controls clr/load).
- Accepts 5-bit input vectors over a valid/ready handshake and drives the pipeline's load, clr and data inputs.
- Tracks which pipeline slots hold real data and presents results on a registered valid/ready output with backpressure.
- Provides run/drain/abort sequencing and a result counter.

Parameters:
- DEPTH, 2, pipeline latency in load-enabled clock edges (number of register stages between a..e and f); must be ≥1.
- CNT_W, 8, width of the result counter.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, synchronous, active-high.
- start  input  1  begin accepting vectors; 1-cycle pulse.
- drain_req  input  1  stop accepting and empty the pipeline; 1-cycle pulse.
- abort  input  1  discard all in-flight data immediately.
- in_valid  input  1  in_data is valid.
- in_data  input  5  {a,b,c,d,e}, with bit4 = a.
- in_ready  output  1  controller accepts in_data this cycle.
- pipe_clr  output  1  clear to pipeline.
- pipe_load  output  1  pipeline register enable.
- pipe_in  output  5  {a,b,c,d,e} to pipeline.
- pipe_f  input  1  pipeline output f.
- out_valid  output  1  out_data holds a result.
- out_data  output  1  result bit.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  state is not IDLE.
- drain_done  output  1  1-cycle pulse when a drain completes.
- result_cnt  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset (clr=1 at an edge): state=IDLE; vld=0; out_valid=0; out_data=0; drain_done=0; result_cnt=0. pipe_clr=1 combinationally while clr=1. Reset overrides every other input, including mid-operation.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN on drain_req.
  - DRAIN→IDLE when vld==0 and (!out_valid or out_ready).
  - abort in any state → IDLE at the next edge.
  - Ignored inputs: start in RUN/DRAIN, drain_req in IDLE/DRAIN.
  - Priority: clr > abort > start/drain_req.
- adv = !out_valid | out_ready (the output register is free or is being emptied).
- pipe_load = adv & (state != IDLE) & !abort. Nothing advances in IDLE.
- in_ready = adv & (state == RUN) & !abort.
- accept = in_valid & in_ready.
- pipe_in = in_data when accept, otherwise 5'b0 (a bubble is loaded).
- Token tracking: vld is a DEPTH-bit shift register. On each pipe_load edge, vld <= {vld[DEPTH-2:0], accept}. vld[DEPTH-1]=1 means pipe_f is valid.
- Output register, on each pipe_load edge:
  - out_valid <= vld[DEPTH-1];
  - out_data <= pipe_f when vld[DEPTH-1], else hold.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Latency: a vector accepted at edge k appears with out_valid=1 after edge k+DEPTH, provided there is no backpressure. Sustained throughput is 1 vector per cycle.
- Backpressure: while out_valid=1 and out_ready=0, pipe_load=0 and in_ready=0. The pipeline and vld freeze and no data is lost or duplicated.
- abort: pipe_clr = clr | abort (combinational). At that edge, vld<=0, out_valid<=0 and state<=IDLE. result_cnt is not cleared. An output handshake completing in the same cycle as abort is not counted.
- result_cnt increments on each out_valid & out_ready edge and wraps from 2^CNT_W-1 to 0.
- drain_done is a registered 1-cycle pulse in the first IDLE cycle after DRAIN exits normally. It does not pulse on abort.
- busy = (state != IDLE).

Test Plan:
- Bench pipeline stub: DEPTH=2 register chain, loaded on pipe_load, cleared on pipe_clr, with f = XOR of the stored vector.
- Stream: clr, then start, then feed 11010, 11011, 01110 back-to-back with out_ready=1 → in_ready=1 each cycle; out_data 1, 0, 1 appear at edges k+2, k+3, k+4; result_cnt=3.
- Backpressure: out_ready=0 for 4 cycles while the first result is valid → out_valid stays 1 with out_data=1, in_ready=0, pipe_load=0. After release, remaining results arrive in order and none are lost.
- Drain: drain_req after 2 accepted vectors → in_ready=0 at once; both results delivered; then state=IDLE, busy=0, drain_done high for exactly 1 cycle.
- Abort: abort with 2 tokens in flight and out_valid=1 → pipe_clr=1 for that cycle; next cycle out_valid=0, busy=0, no drain_done, result_cnt unchanged.
- Wrap and collisions: with CNT_W=2, 5 handshakes → result_cnt=1. start and drain_req together in IDLE → RUN. clr asserted during RUN → all outputs at reset values the next cycle.
